weighted_rank_order_stream: RTL and testbench

//  Streaming weighted order-statistic filter; successor of the masked rank-order filter.

---
 rtl/weighted_rank_order_stream.sv | 121 ++++++++++++
 tb/tb_weighted_rank_order_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rank_order_stream.sv
// weighted_rank_order_stream: 3-stage weighted order-statistic filter over an N-tap window; `WROS_EDGE_REPLICATE_EN pads the window with the first sample.
module weighted_rank_order_stream #(
  parameter int N = 7,
  parameter int DATA_BITS = 8,
  parameter int WEIGHT_BITS = 3,
  localparam int SUM_BITS = $clog2(N*(2**WEIGHT_BITS-1)+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [DATA_BITS-1:0]     i_data,
  input  logic                     cfg_we,
  input  logic [WEIGHT_BITS*N-1:0] cfg_weights,
  input  logic [SUM_BITS-1:0]      cfg_rank,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DATA_BITS-1:0]     o_data,
  output logic                     o_primed
);
  localparam int FILL_BITS = $clog2(N+1);
  logic [N-1:0][DATA_BITS-1:0] win_q, win_d, s1_s_q, s1_s_d, s2_s_q, s2_s_d;
  logic [FILL_BITS-1:0] fill_q, fill_d;
  logic [WEIGHT_BITS*N-1:0] sh_w_q, sh_w_d, s1_w_q, s1_w_d, s2_w_q, s2_w_d;
  logic [SUM_BITS-1:0] sh_r_q, sh_r_d, s1_r_q, s1_r_d, s2_r_q, s2_r_d, s2_t_q, s2_t_d, t, r_eff;
  logic [N-1:0][SUM_BITS-1:0] s2_cw_q, s2_cw_d, cw;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, o_valid_q, o_valid_d;
  logic [DATA_BITS-1:0] o_data_q, o_data_d, sel;
  logic stall, acc, ld2, ld3;
  always_comb begin
    stall = o_valid_q & ~o_ready;
    acc = i_valid & ~stall;
    ld2 = ~stall & s1_v_q;
    ld3 = ~stall & s2_v_q;
    win_d = win_q;
    fill_d = fill_q;
    if (acc) begin
      win_d = {win_q[N-2:0], i_data};
      fill_d = fill_q == FILL_BITS'(N) ? fill_q : fill_q + 1'b1;
`ifdef WROS_EDGE_REPLICATE_EN
      if (fill_q == '0) begin
        win_d = {N{i_data}};
        fill_d = FILL_BITS'(N);
      end
`endif
    end
    sh_w_d = cfg_we ? cfg_weights : sh_w_q;
    sh_r_d = cfg_we ? cfg_rank : sh_r_q;
    // S1 takes the pre-edge shadow values, so a same-cycle cfg_we only affects later samples
    s1_v_d = stall ? s1_v_q : acc & (fill_d == FILL_BITS'(N));
    s1_s_d = acc ? win_d : s1_s_q;
    s1_w_d = acc ? sh_w_q : s1_w_q;
    s1_r_d = acc ? sh_r_q : s1_r_q;
  end
  always_comb begin
    t = '0;
    for (int i = 0; i < N; i++) begin
      cw[i] = '0;
      for (int j = 0; j < N; j++)
        cw[i] = s1_s_q[j] <= s1_s_q[i] ? cw[i] + SUM_BITS'(s1_w_q[j*WEIGHT_BITS +: WEIGHT_BITS]) : cw[i];
      t = t + SUM_BITS'(s1_w_q[i*WEIGHT_BITS +: WEIGHT_BITS]);
    end
    s2_v_d = stall ? s2_v_q : s1_v_q;
    s2_s_d = ld2 ? s1_s_q : s2_s_q;
    s2_w_d = ld2 ? s1_w_q : s2_w_q;
    s2_r_d = ld2 ? s1_r_q : s2_r_q;
    s2_t_d = ld2 ? t : s2_t_q;
    s2_cw_d = ld2 ? cw : s2_cw_q;
  end
  always_comb begin
    r_eff = s2_r_q == '0 ? SUM_BITS'(1) : (s2_r_q > s2_t_q ? s2_t_q : s2_r_q);
    sel = '1;
    // the largest weighted tap always reaches T, so a candidate exists whenever T > 0
    for (int i = 0; i < N; i++)
      sel = (s2_w_q[i*WEIGHT_BITS +: WEIGHT_BITS] != '0) && (s2_cw_q[i] >= r_eff) && (s2_s_q[i] < sel) ? s2_s_q[i] : sel;
    sel = s2_t_q == '0 ? '0 : sel;
    o_valid_d = stall ? o_valid_q : s2_v_q;
    o_data_d = ld3 ? sel : o_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
      fill_q <= '0;
      sh_w_q <= {N{WEIGHT_BITS'(1)}};
      sh_r_q <= SUM_BITS'((N+1)/2);
      s1_v_q <= 1'b0;
      s1_s_q <= '0;
      s1_w_q <= '0;
      s1_r_q <= '0;
      s2_v_q <= 1'b0;
      s2_s_q <= '0;
      s2_w_q <= '0;
      s2_r_q <= '0;
      s2_t_q <= '0;
      s2_cw_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
    end else begin
      win_q <= win_d;
      fill_q <= fill_d;
      sh_w_q <= sh_w_d;
      sh_r_q <= sh_r_d;
      s1_v_q <= s1_v_d;
      s1_s_q <= s1_s_d;
      s1_w_q <= s1_w_d;
      s1_r_q <= s1_r_d;
      s2_v_q <= s2_v_d;
      s2_s_q <= s2_s_d;
      s2_w_q <= s2_w_d;
      s2_r_q <= s2_r_d;
      s2_t_q <= s2_t_d;
      s2_cw_q <= s2_cw_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
    end
  end
  assign i_ready = ~stall;
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_primed = fill_q == FILL_BITS'(N);
endmodule

// File: tb/tb_weighted_rank_order_stream.sv
// tb_weighted_rank_order_stream: random and directed stimulus checked against a sorted-multiset reference model.
module tb_weighted_rank_order_stream;
  logic clk, rst, i_valid, i_ready, cfg_we, o_valid, o_ready, o_primed;
  logic [7:0] i_data, o_data;
  logic [20:0] cfg_weights;
  logic [5:0] cfg_rank;
  int errors = 0, checks = 0, cyc = 0, stall_total = 0;
  int win[7];
  int fill = 0, sh_r = 4, prev_data = 0;
  logic [20:0] sh_w = 21'o1111111;
  bit prev_stall = 0, rand_en = 0;
  int q_data[$], q_acc[$], q_st[$], got[$];
  int stream[7] = '{10, 50, 20, 40, 30, 70, 60};

  weighted_rank_order_stream dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .cfg_we(cfg_we), .cfg_weights(cfg_weights), .cfg_rank(cfg_rank),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_primed(o_primed));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expand every tap into w copies, sort, and index by the clamped rank
  function automatic int model_sel();
    int arr[64];
    int n = 0, r, tmp;
    for (int k = 0; k < 7; k++)
      for (int m = 0; m < int'(sh_w[k*3 +: 3]); m++) begin
        arr[n] = win[k];
        n++;
      end
    if (n == 0) return 0;
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n - 1 - a; b++)
        if (arr[b] > arr[b+1]) begin
          tmp = arr[b]; arr[b] = arr[b+1]; arr[b+1] = tmp;
        end
    r = sh_r < 1 ? 1 : (sh_r > n ? n : sh_r);
    return arr[r-1];
  endfunction

  always @(negedge clk) begin
    int due;
    bit st;
    cyc++;
    if (rst) begin
      q_data.delete(); q_acc.delete(); q_st.delete();
      fill = 0;
      foreach (win[k]) win[k] = 0;
      sh_w = 21'o1111111;
      sh_r = 4;
      prev_stall = 0;
    end else begin
      chk("i_ready", int'(i_ready), int'(!(o_valid && !o_ready)));
      chk("o_primed", int'(o_primed), int'(fill == 7));
      if (prev_stall) begin
        chk("stall_valid", int'(o_valid), 1);
        chk("stall_data", int'(o_data), prev_data);
      end
      if (q_data.size() == 0) chk("idle_valid", int'(o_valid), 0);
      else begin
        due = q_acc[0] + 3 + (stall_total - q_st[0]);
        if (o_valid && o_ready) begin
          chk("o_data", int'(o_data), q_data[0]);
          chk("latency", cyc, due);
          got.push_back(int'(o_data));
          void'(q_data.pop_front()); void'(q_acc.pop_front()); void'(q_st.pop_front());
        end else if (!o_valid && cyc >= due) chk("late_valid", int'(o_valid), 1);
      end
      if (i_valid && i_ready) begin
`ifdef WROS_EDGE_REPLICATE_EN
        if (fill == 0) begin
          foreach (win[k]) win[k] = int'(i_data);
          fill = 7;
        end else
`endif
        begin
          for (int k = 6; k > 0; k--) win[k] = win[k-1];
          win[0] = int'(i_data);
          if (fill < 7) fill++;
        end
        if (fill == 7) begin
          q_data.push_back(model_sel());
          q_acc.push_back(cyc);
          q_st.push_back(stall_total);
        end
      end
      if (cfg_we) begin
        sh_w = cfg_weights;
        sh_r = int'(cfg_rank);
      end
      st = o_valid && !o_ready;
      stall_total += int'(st);
      prev_stall = st;
      prev_data = int'(o_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    int n = 0;
    i_valid = 1;
    i_data = d[7:0];
    @(negedge clk);
    while (!i_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!i_ready) chk("send_ready", int'(i_ready), 1);
    tick();
    i_valid = 0;
  endtask

  task automatic set_cfg(input logic [20:0] w, input int r);
    cfg_weights = w;
    cfg_rank = r[5:0];
    cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic run_stream();
    foreach (stream[k]) send(stream[k]);
    drain();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_primed", int'(o_primed), 0);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_i_ready", int'(i_ready), 1);
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1; i_valid = 0; i_data = 0; cfg_we = 0; cfg_weights = 0; cfg_rank = 0; o_ready = 1;
    tick();
    tick();
    do_reset();
`ifdef WROS_EDGE_REPLICATE_EN
    send(25);
    chk("pad_primed", int'(o_primed), 1);
    tick();
    tick();
    chk("pad_valid", int'(o_valid), 1);
    chk("pad_data", int'(o_data), 25);
    drain();
    set_cfg(21'o1111111, 1);
    send(5);
    drain();
    chk("pad_rank1", got[got.size()-1], 5);
`else
    for (int k = 0; k < 6; k++) send(stream[k]);
    chk("primed_6", int'(o_primed), 0);
    send(stream[6]);
    chk("primed_7", int'(o_primed), 1);
    tick();
    chk("valid_c2", int'(o_valid), 0);
    tick();
    chk("valid_c3", int'(o_valid), 1);
    chk("median", int'(o_data), 40);
    drain();
    set_cfg(21'o1111113, 5); run_stream(); chk("w_rank5", got[got.size()-1], 50);
    set_cfg(21'o1111113, 7); run_stream(); chk("w_rank7", got[got.size()-1], 60);
    set_cfg(21'o1111113, 0); run_stream(); chk("w_rank0", got[got.size()-1], 10);
    set_cfg(21'o1111113, 63); run_stream(); chk("w_rank63", got[got.size()-1], 70);
    set_cfg(21'o1111000, 1); run_stream(); chk("mask_rank1", got[got.size()-1], 10);
    set_cfg(21'o1111000, 4); run_stream(); chk("mask_rank4", got[got.size()-1], 50);
    set_cfg(21'o0000000, 4); run_stream(); chk("all_masked", got[got.size()-1], 0);
    set_cfg(21'($urandom), int'($urandom_range(0, 50)));
    n0 = got.size();
    fork
      for (int k = 0; k < 20; k++) send(int'($urandom_range(0, 255)));
      begin
        repeat (10) tick();
        o_ready = 0;
        repeat (5) tick();
        o_ready = 1;
      end
    join
    drain();
    chk("bp_count", got.size() - n0, 20);
    rand_en = 1;
    fork
      begin
        while (rand_en) begin
          o_ready = $urandom_range(0, 3) != 0;
          tick();
        end
        o_ready = 1;
      end
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          if ($urandom_range(0, 9) == 0) begin
            cfg_weights = 21'($urandom);
            cfg_rank = 6'($urandom_range(0, 50));
            cfg_we = 1;
          end
          send(int'($urandom_range(0, 255)));
          cfg_we = 0;
        end
        rand_en = 0;
      end
    join
    drain();
    do_reset();
    foreach (stream[k]) send(stream[k]);
    cfg_weights = 21'o1111111;
    cfg_rank = 1;
    cfg_we = 1;
    send(80);
    cfg_we = 0;
    send(5);
    drain();
    chk("race_old_cfg", got[got.size()-2], 50);
    chk("race_new_cfg", got[got.size()-1], 5);
    send(7);
    tick();
    tick();
    chk("pre_rst_valid", int'(o_valid), 1);
    do_reset();
    n0 = got.size();
    for (int k = 0; k < 6; k++) send(stream[k]);
    drain();
    chk("post_rst_primed", int'(o_primed), 0);
    send(stream[6]);
    drain();
    chk("post_rst_count", got.size() - n0, 1);
    chk("post_rst_median", got[got.size()-1], 40);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
